// File: rtl/vend_controller.sv
`timescale 1ns/1ps
// Credit-and-dispense controller for the lab 9 vending machine: accumulates coin credit,
// releases products and pays change one nickel per clock-enable tick.
module vend_controller #(
    parameter logic [7:0] MAX_BAL = 8'd95
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic [2:0] coin,
    input  logic [3:0] product,
    input  logic [7:0] cost,
    input  logic       cancel,
    output logic [7:0] balance,
    output logic       dispense,
    output logic       change,
    output logic       reject,
    output logic       deny,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] coin_q;
    logic [3:0] product_q;
    logic       cancel_q;
    logic [2:0] coin_ev;
    logic       buy_ev;
    logic       cancel_ev;
    logic [7:0] cost_ev;

    logic [7:0] balance_next;
    logic       dispense_next;
    logic       change_next;
    logic       reject_next;
    logic       deny_next;
    logic       busy_next;

    logic       open;
    logic       cancel_go;
    logic       buy_go;
    logic       coin_go;
    logic       coin_one;
    logic       can_buy;
    logic       fits;
    logic       capture_ok;
    logic [7:0] coin_value;

    always_comb begin
        case (coin_ev)
            3'b001:  coin_value = 8'd5;
            3'b010:  coin_value = 8'd10;
            3'b100:  coin_value = 8'd25;
            default: coin_value = 8'd0;
        endcase
    end

    // Events are registered one cycle after the edge is seen; priority is cancel, purchase, coin.
    assign open       = (state == S_IDLE) || (state == S_CREDIT);
    assign cancel_go  = cancel_ev && (state == S_CREDIT);
    assign buy_go     = buy_ev && open && !cancel_go;
    assign coin_go    = (|coin_ev) && open && !cancel_go && !buy_go;
    assign coin_one   = $onehot(coin_ev);
    assign can_buy    = balance >= cost_ev;
    assign fits       = ({1'b0, balance} + {1'b0, coin_value}) <= {1'b0, MAX_BAL};
    assign capture_ok = open && (state_next != S_VEND);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_CREDIT: begin
                if (cancel_go)
                    state_next = S_CHANGE;
                else if (buy_go && can_buy)
                    state_next = S_VEND;
                else if (coin_go && coin_one && fits)
                    state_next = S_CREDIT;
            end
            S_VEND:
                state_next = (balance != cost_ev) ? S_CHANGE : S_IDLE;
            S_CHANGE: begin
                if (balance == 8'd0)
                    state_next = S_IDLE;
                else if (clk_en && (balance <= 8'd5))
                    state_next = S_IDLE;
            end
            default:
                state_next = S_IDLE;
        endcase
    end

    always_comb begin
        balance_next  = balance;
        dispense_next = (state_next == S_VEND);
        change_next   = 1'b0;
        reject_next   = 1'b0;
        deny_next     = 1'b0;
        busy_next     = (state_next == S_VEND) || (state_next == S_CHANGE);
        case (state)
            S_IDLE, S_CREDIT: begin
                if (buy_go && !can_buy)
                    deny_next = 1'b1;
                if (coin_go) begin
                    if (coin_one && fits)
                        balance_next = balance + coin_value;
                    else
                        reject_next = 1'b1;
                end
            end
            S_VEND: begin
                balance_next = balance - cost_ev;
                reject_next  = |coin_ev;
            end
            S_CHANGE: begin
                reject_next = |coin_ev;
                if (clk_en && (balance != 8'd0)) begin
                    change_next  = 1'b1;
                    balance_next = balance - 8'd5;
                end
            end
            default: ;
        endcase
    end

    // Edge registers reset to ones so a button held through reset release never fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            coin_q    <= '1;
            product_q <= '1;
            cancel_q  <= 1'b1;
            coin_ev   <= '0;
            buy_ev    <= 1'b0;
            cancel_ev <= 1'b0;
            cost_ev   <= '0;
            balance   <= '0;
            dispense  <= 1'b0;
            change    <= 1'b0;
            reject    <= 1'b0;
            deny      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            coin_q    <= coin;
            product_q <= product;
            cancel_q  <= cancel;
            coin_ev   <= coin & ~coin_q;
            buy_ev    <= (|(product & ~product_q)) && $onehot(product) && (cost != 8'd0);
            cancel_ev <= cancel && !cancel_q;
            if (capture_ok && (|(product & ~product_q)))
                cost_ev <= cost;
            balance   <= balance_next;
            dispense  <= dispense_next;
            change    <= change_next;
            reject    <= reject_next;
            deny      <= deny_next;
            busy      <= busy_next;
        end
    end

endmodule
